// File: rtl/array_cell.sv
// array_cell: WIDTH independent unsigned array-multiplier cells.
// Each lane forms the partial product a&b, adds it to the incoming sum bit
// and carry bit with a full adder, and returns the sum and carry bits.
// The outputs are either combinational or registered, selected by REG_OUT.
// Registered outputs give exactly one cycle of latency. They have no enable
// and no handshake. An asynchronous reset clears them to zero.
module array_cell #(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] s_in,
    input  logic [WIDTH-1:0] c_in,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c_out
);

    // Per-lane partial product and full-adder result. Lanes never interact.
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] carry_d;

    // Bitwise full adder across all lanes; the majority term is the carry.
    always_comb begin
        pp      = a & b;
        sum_d   = pp ^ s_in ^ c_in;
        carry_d = (pp & s_in) | (pp & c_in) | (s_in & c_in);
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [WIDTH-1:0] sum_q;
            logic [WIDTH-1:0] carry_q;

            // Output flops: reset has priority over the load on every edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_q   <= '0;
                    carry_q <= '0;
                end else begin
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                end
            end

            assign s     = sum_q;
            assign c_out = carry_q;
        end else begin : g_comb
            // The clock and reset have no function in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk | rst;

            assign s     = sum_d;
            assign c_out = carry_d;
        end
    endgenerate

endmodule

// File: tb/tb_array_cell.sv
// Testbench for array_cell covering several WIDTH/REG_OUT configurations.
module tb_array_cell;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    // WIDTH=1 combinational
    logic a1c, b1c, si1c, ci1c, s1c, co1c;
    // WIDTH=1 registered
    logic a1r, b1r, si1r, ci1r, s1r, co1r;
    // WIDTH=4 registered
    logic [3:0] a4, b4, si4, ci4, s4, co4;
    // WIDTH=8, both modes share inputs
    logic [7:0] a8, b8, si8, ci8, s8c, co8c, s8r, co8r;

    array_cell #(.WIDTH(1), .REG_OUT(0)) u_w1_comb (
        .clk(clk), .rst(rst), .a(a1c), .b(b1c), .s_in(si1c), .c_in(ci1c),
        .s(s1c), .c_out(co1c)
    );
    array_cell #(.WIDTH(1), .REG_OUT(1)) u_w1_reg (
        .clk(clk), .rst(rst), .a(a1r), .b(b1r), .s_in(si1r), .c_in(ci1r),
        .s(s1r), .c_out(co1r)
    );
    array_cell #(.WIDTH(4), .REG_OUT(1)) u_w4_reg (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .s_in(si4), .c_in(ci4),
        .s(s4), .c_out(co4)
    );
    array_cell #(.WIDTH(8), .REG_OUT(0)) u_w8_comb (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .s_in(si8), .c_in(ci8),
        .s(s8c), .c_out(co8c)
    );
    array_cell #(.WIDTH(8), .REG_OUT(1)) u_w8_reg (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .s_in(si8), .c_in(ci8),
        .s(s8r), .c_out(co8r)
    );

    // ---------------- reference model ----------------
    // Per lane: add a&b + s_in + c_in as integers; bit 0 is the sum, bit 1 the carry.
    function automatic logic [15:0] ref_model(input logic [7:0] ra, input logic [7:0] rb,
                                              input logic [7:0] rs, input logic [7:0] rc);
        logic [7:0] es;
        logic [7:0] ec;
        es = '0;
        ec = '0;
        for (int i = 0; i < 8; i++) begin
            int total;
            total = int'(ra[i] & rb[i]) + int'(rs[i]) + int'(rc[i]);
            es[i] = (total % 2) == 1;
            ec[i] = (total / 2) == 1;
        end
        return {ec, es};
    endfunction

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] s_tab;
        logic [15:0] c_tab;
        logic [15:0] expv;
        logic [15:0] regexp;

        {a1c, b1c, si1c, ci1c} = '0;
        {a1r, b1r, si1r, ci1r} = '0;
        {a4, b4, si4, ci4}     = '0;
        {a8, b8, si8, ci8}     = '0;

        // Reset state of the registered builds, before any clock edge.
        #2;
        check("rst_w1_s", {7'b0, s1r}, 8'h00);
        check("rst_w1_c", {7'b0, co1r}, 8'h00);
        check("rst_w4_s", {4'b0, s4}, 8'h00);
        check("rst_w4_c", {4'b0, co4}, 8'h00);
        check("rst_w8_s", s8r, 8'h00);
        check("rst_w8_c", co8r, 8'h00);

        // Exhaustive truth table, WIDTH=1 combinational; bit v holds the value for {c_in,s_in,b,a}=v.
        s_tab = 16'h8778;
        c_tab = 16'hF880;
        for (int v = 0; v < 16; v++) begin
            logic [3:0] vv;
            vv = 4'(v);
            {ci1c, si1c, b1c, a1c} = vv;
            #10;
            check($sformatf("exh_s_%0d", v), {7'b0, s1c}, {7'b0, s_tab[v]});
            check($sformatf("exh_c_%0d", v), {7'b0, co1c}, {7'b0, c_tab[v]});
        end

        // Outputs stay cleared across edges while reset is held.
        @(posedge clk); #1;
        check("rst_hold0_s", {7'b0, s1r}, 8'h00);

        // Single lane registered: all ones, outputs hold until the edge.
        @(negedge clk);
        rst = 1'b0;
        {a1r, b1r, si1r, ci1r} = 4'b1111;
        #1;
        check("w1_pre_s", {7'b0, s1r}, 8'h00);
        check("w1_pre_c", {7'b0, co1r}, 8'h00);
        @(posedge clk); #1;
        check("w1_post_s", {7'b0, s1r}, 8'h01);
        check("w1_post_c", {7'b0, co1r}, 8'h01);

        // Asynchronous reset between edges clears immediately.
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_s", {7'b0, s1r}, 8'h00);
        check("arst_c", {7'b0, co1r}, 8'h00);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("arst_hold_s", {7'b0, s1r}, 8'h00);
            check("arst_hold_c", {7'b0, co1r}, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        a1r = 1'b1; b1r = 1'b0; si1r = 1'b1; ci1r = 1'b0;
        #1;
        check("rel_pre_s", {7'b0, s1r}, 8'h00);
        @(posedge clk); #1;
        check("rel_post_s", {7'b0, s1r}, 8'h01);
        check("rel_post_c", {7'b0, co1r}, 8'h00);

        // WIDTH=4 directed vector.
        @(negedge clk);
        a4 = 4'b1111; b4 = 4'b1010; si4 = 4'b0110; ci4 = 4'b0011;
        @(posedge clk); #1;
        check("w4_s", {4'b0, s4}, 8'b0000_1111);
        check("w4_c", {4'b0, co4}, 8'b0000_0010);

        // Random WIDTH=8, both builds against the reference model.
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a8  = 8'($urandom_range(0, 255));
            b8  = 8'($urandom_range(0, 255));
            si8 = 8'($urandom_range(0, 255));
            ci8 = 8'($urandom_range(0, 255));
            expv = ref_model(a8, b8, si8, ci8);
            exp_q.push_back(expv);
            #1;
            check("rnd_comb_s", s8c, expv[7:0]);
            check("rnd_comb_c", co8c, expv[15:8]);
            @(posedge clk); #1;
            regexp = exp_q.pop_front();
            check("rnd_reg_s", s8r, regexp[7:0]);
            check("rnd_reg_c", co8r, regexp[15:8]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
